// File: rtl/dma_channel_scheduler_if.sv
// Channel request/response and DMA register bundle between requesters, scheduler and DMA engine.
// The scheduler uses the slave modport; requesters and DMA model use master.
interface dma_channel_scheduler_if #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned ModeWidth    = 2
);
  localparam int unsigned ChW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]              ch_req_valid;
  logic [NUM_CH-1:0]              ch_req_ready;
  logic [NUM_CH*RegDataWidth-1:0] ch_src_addr;
  logic [NUM_CH*RegDataWidth-1:0] ch_dest_addr;
  logic [NUM_CH*RegDataWidth-1:0] ch_size;
  logic [NUM_CH-1:0]              ch_verify;
  logic [NUM_CH-1:0]              ch_resp_valid;
  logic [1:0]                     ch_resp_status;
  logic [RegDataWidth-1:0]        dma_src_addr;
  logic [RegDataWidth-1:0]        dma_dest_addr;
  logic [RegDataWidth-1:0]        dma_transfer_size;
  logic [ModeWidth-1:0]           dma_mode;
  logic                           dma_done;
  logic [1:0]                     dma_success;
  logic                           busy;
  logic [ChW-1:0]                 cur_ch;

  modport slave (
    input  ch_req_valid, ch_src_addr, ch_dest_addr, ch_size, ch_verify, dma_done, dma_success,
    output ch_req_ready, ch_resp_valid, ch_resp_status, dma_src_addr, dma_dest_addr,
           dma_transfer_size, dma_mode, busy, cur_ch
  );

  modport master (
    output ch_req_valid, ch_src_addr, ch_dest_addr, ch_size, ch_verify, dma_done, dma_success,
    input  ch_req_ready, ch_resp_valid, ch_resp_status, dma_src_addr, dma_dest_addr,
           dma_transfer_size, dma_mode, busy, cur_ch
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Round-robin multi-channel front end for a single DMA engine; returns per-channel status.
// Optional DMA_AUTO_VERIFY_EN: every copy is followed by a verify pass before responding.
module dma_channel_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RegDataWidth   = 32,
  parameter int unsigned ModeWidth      = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  dma_channel_scheduler_if.slave bus
);
  localparam int unsigned ChW  = $clog2(NUM_CH);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ModeWidth-1:0] ModeCopy   = ModeWidth'(1);
  localparam logic [ModeWidth-1:0] ModeVerify = ModeWidth'(2);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
`ifdef DMA_AUTO_VERIFY_EN
    StVLaunch,
    StVWait,
`endif
    StDrain,
    StResp
  } state_e;

  state_e                  r_state, w_state_d;
  logic [ChW-1:0]          r_rr_ptr, r_cur_ch, w_grant_idx;
  logic [RegDataWidth-1:0] r_src, r_dest, r_size;
  logic                    r_verify;
  logic [1:0]              r_status, w_status_d, w_vstatus;
  logic [CntW-1:0]         r_tmo, w_tmo_d;
  logic                    w_found, w_tmo_expired;
  logic [NUM_CH-1:0]       w_grant, w_resp_valid;
  logic [ModeWidth-1:0]    w_mode;
  logic [RegDataWidth-1:0] w_sel_src, w_sel_dest, w_sel_size;
  int unsigned             w_idx;

  // First valid channel strictly after the RR pointer, wrapping around.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_idx       = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      w_idx = (32'(r_rr_ptr) + i) % NUM_CH;
      if (!w_found && bus.ch_req_valid[w_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = ChW'(w_idx);
      end
    end
    w_grant = '0;
    if (w_found) w_grant[w_grant_idx] = 1'b1;
  end

  assign w_sel_src  = bus.ch_src_addr[32'(w_grant_idx)*RegDataWidth +: RegDataWidth];
  assign w_sel_dest = bus.ch_dest_addr[32'(w_grant_idx)*RegDataWidth +: RegDataWidth];
  assign w_sel_size = bus.ch_size[32'(w_grant_idx)*RegDataWidth +: RegDataWidth];

  // Anything other than an explicit pass is reported as a verify failure.
  assign w_vstatus     = (bus.dma_success == 2'b01) ? 2'b01 : 2'b10;
  assign w_tmo_expired = (r_tmo == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_d    = r_state;
    w_status_d   = r_status;
    w_tmo_d      = r_tmo;
    w_mode       = '0;
    w_resp_valid = '0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          if (w_sel_size == '0) begin
            w_status_d = {1'b0, bus.ch_verify[w_grant_idx]};
            w_state_d  = StResp;
          end else begin
            w_state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        w_mode    = r_verify ? ModeVerify : ModeCopy;
        w_tmo_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        w_tmo_d = r_tmo + CntW'(1);
        if (bus.dma_done) begin
          if (r_verify) begin
            w_status_d = w_vstatus;
            w_state_d  = StResp;
          end else begin
`ifdef DMA_AUTO_VERIFY_EN
            w_state_d = StVLaunch;
`else
            w_status_d = 2'b00;
            w_state_d  = StResp;
`endif
          end
        end else if (w_tmo_expired) begin
          w_status_d = 2'b11;
          w_state_d  = StDrain;
        end
      end
`ifdef DMA_AUTO_VERIFY_EN
      StVLaunch: begin
        w_mode    = ModeVerify;
        w_tmo_d   = '0;
        w_state_d = StVWait;
      end
      StVWait: begin
        w_tmo_d = r_tmo + CntW'(1);
        if (bus.dma_done) begin
          w_status_d = w_vstatus;
          w_state_d  = StResp;
        end else if (w_tmo_expired) begin
          w_status_d = 2'b11;
          w_state_d  = StDrain;
        end
      end
`endif
      // The DMA cannot be aborted, so wait for its done before freeing it.
      StDrain: if (bus.dma_done) w_state_d = StResp;
      StResp: begin
        w_resp_valid[r_cur_ch] = 1'b1;
        w_state_d              = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_rr_ptr <= ChW'(NUM_CH - 1);
      r_cur_ch <= '0;
      r_src    <= '0;
      r_dest   <= '0;
      r_size   <= '0;
      r_verify <= 1'b0;
      r_status <= 2'b00;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_status <= w_status_d;
      r_tmo    <= w_tmo_d;
      if (r_state == StIdle && w_found) begin
        r_rr_ptr <= w_grant_idx;
        r_cur_ch <= w_grant_idx;
        r_src    <= w_sel_src;
        r_dest   <= w_sel_dest;
        r_size   <= w_sel_size;
        r_verify <= bus.ch_verify[w_grant_idx];
      end
    end
  end

  assign bus.ch_req_ready      = (r_state == StIdle && rst_n) ? w_grant : '0;
  assign bus.ch_resp_valid     = w_resp_valid;
  assign bus.ch_resp_status    = (r_state == StResp) ? r_status : 2'b00;
  assign bus.dma_src_addr      = r_src;
  assign bus.dma_dest_addr     = r_dest;
  assign bus.dma_transfer_size = r_size;
  assign bus.dma_mode          = w_mode;
  assign bus.busy              = (r_state != StIdle);
  assign bus.cur_ch            = r_cur_ch;
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Scoreboard bench for dma_channel_scheduler: expected grants, DMA launches and responses are
// queued by the stimulus and consumed by a monitor/DMA-model process.
module tb_dma_channel_scheduler;
  localparam int unsigned NumCh     = 4;
  localparam int unsigned TmoCycles = 16;
`ifdef DMA_AUTO_VERIFY_EN
  localparam logic [1:0] CopySt = 2'b01;
`else
  localparam logic [1:0] CopySt = 2'b00;
`endif

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] src;
    logic [31:0] dest;
    logic [31:0] size;
  } launch_t;

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] st;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_channel_scheduler_if #(.NUM_CH(NumCh)) bus ();

  dma_channel_scheduler #(
    .NUM_CH        (NumCh),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0]      d_src  [NumCh];
  logic [31:0]      d_dest [NumCh];
  logic [31:0]      d_size [NumCh];
  logic [NumCh-1:0] d_verify    = '0;
  int               posted [NumCh] = '{default: 0};
  int               taken  [NumCh] = '{default: 0};
  logic [NumCh-1:0] force_valid = '1;
  logic [1:0]       tb_success  = 2'b01;
  int               dma_lat     = 3;
  int               manual_req  = 0;
  int               manual_ack  = 0;

  launch_t q_launch[$];
  int      q_grant[$];
  resp_t   q_resp[$];

  int n_vec  = 0;
  int n_fail = 0;

  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      bus.ch_src_addr[i*32 +: 32]  = d_src[i];
      bus.ch_dest_addr[i*32 +: 32] = d_dest[i];
      bus.ch_size[i*32 +: 32]      = d_size[i];
      bus.ch_req_valid[i]          = force_valid[i] | (posted[i] != taken[i]);
    end
  end
  assign bus.ch_verify   = d_verify;
  assign bus.dma_success = tb_success;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [127:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: unexpected event 0x%0h, expected none", name, act);
  endfunction

  // DMA model + monitor: one process so the DMA side has a single driver.
  launch_t          cur_launch;
  launch_t          exp_launch;
  resp_t            exp_resp;
  logic             pending = 1'b0;
  int               cnt     = 0;
  int               exp_g;
  logic [NumCh-1:0] hs_seen = '0;

  initial begin
    bus.dma_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NumCh; i++) if (hs_seen[i]) taken[i]++;
      hs_seen      = '0;
      bus.dma_done = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending)
          check("dma_hold", {bus.dma_mode, bus.dma_src_addr, bus.dma_dest_addr,
                bus.dma_transfer_size}, {2'b00, cur_launch.src, cur_launch.dest,
                cur_launch.size});
        if (manual_req != manual_ack) begin
          bus.dma_done = 1'b1;
          manual_ack++;
          pending = 1'b0;
        end else if (pending && dma_lat > 0) begin
          if (cnt <= 1) begin
            bus.dma_done = 1'b1;
            pending      = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (bus.dma_mode != '0) begin
          cur_launch = {bus.dma_mode, bus.dma_src_addr, bus.dma_dest_addr,
                        bus.dma_transfer_size};
          if (q_launch.size() == 0) begin
            unexpected("dma_launch", cur_launch);
          end else begin
            exp_launch = q_launch.pop_front();
            check("dma_launch", cur_launch, exp_launch);
          end
          pending = 1'b1;
          cnt     = dma_lat;
        end
      end
      @(negedge clk);
      if (!rst_n)
        check("reset_outputs", {bus.ch_req_ready, bus.ch_resp_valid, bus.dma_mode, bus.busy}, '0);
      hs_seen = bus.ch_req_valid & bus.ch_req_ready;
      if (hs_seen != '0) begin
        if (q_grant.size() == 0) begin
          unexpected("grant", bus.ch_req_ready);
        end else begin
          exp_g = q_grant.pop_front();
          check("grant", bus.ch_req_ready, NumCh'(1) << exp_g);
        end
      end
      if (bus.ch_resp_valid != '0) begin
        if (q_resp.size() == 0) begin
          unexpected("resp", {bus.ch_resp_valid, bus.ch_resp_status});
        end else begin
          exp_resp = q_resp.pop_front();
          check("resp", {bus.ch_resp_valid, bus.ch_resp_status},
                {NumCh'(1) << exp_resp.ch, exp_resp.st});
        end
      end
    end
  end

  task automatic post(input int ch, input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] z, input logic v, input int times);
    d_src[ch]    = s;
    d_dest[ch]   = d;
    d_size[ch]   = z;
    d_verify[ch] = v;
    posted[ch]   = posted[ch] + times;
  endtask

  task automatic expect_copy(input int ch, input logic [31:0] s, input logic [31:0] d,
                             input logic [31:0] z);
    q_grant.push_back(ch);
    q_launch.push_back({2'd1, s, d, z});
`ifdef DMA_AUTO_VERIFY_EN
    q_launch.push_back({2'd2, s, d, z});
`endif
    q_resp.push_back({3'(ch), CopySt});
  endtask

  task automatic expect_verify(input int ch, input logic [31:0] s, input logic [31:0] d,
                               input logic [31:0] z, input logic [1:0] st);
    q_grant.push_back(ch);
    q_launch.push_back({2'd2, s, d, z});
    q_resp.push_back({3'(ch), st});
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_launch.size() == 0 && q_grant.size() == 0 && q_resp.size() == 0 && !bus.busy &&
          bus.ch_req_valid == '0) break;
    end
    check(name, 1'(i < 400), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    force_valid = '1;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 force_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NumCh; i++) begin
      d_src[i]  = '0;
      d_dest[i] = '0;
      d_size[i] = '0;
    end
    do_reset();

    // Single copy on ch1.
    @(posedge clk); #1;
    expect_copy(1, 32'h10, 32'h40, 32'd8);
    post(1, 32'h10, 32'h40, 32'd8, 1'b0, 1);
    wait_idle("drain_ch1_copy");

    // All four channels pending at once, ch0 twice: round-robin 0,1,2,3,0.
    do_reset();
    @(posedge clk); #1;
    expect_copy(0, 32'h100, 32'h200, 32'd4);
    expect_copy(1, 32'h110, 32'h210, 32'd4);
    expect_copy(2, 32'h120, 32'h220, 32'd4);
    expect_copy(3, 32'h130, 32'h230, 32'd4);
    expect_copy(0, 32'h100, 32'h200, 32'd4);
    post(0, 32'h100, 32'h200, 32'd4, 1'b0, 2);
    post(1, 32'h110, 32'h210, 32'd4, 1'b0, 1);
    post(2, 32'h120, 32'h220, 32'd4, 1'b0, 1);
    post(3, 32'h130, 32'h230, 32'd4, 1'b0, 1);
    wait_idle("drain_round_robin");

    // Verify with explicit fail, then with an illegal success code.
    @(posedge clk); #1;
    tb_success = 2'b10;
    expect_verify(2, 32'h1000, 32'h2000, 32'd12, 2'b10);
    post(2, 32'h1000, 32'h2000, 32'd12, 1'b1, 1);
    wait_idle("drain_verify_fail");
    @(posedge clk); #1;
    tb_success = 2'b11;
    expect_verify(3, 32'h3000, 32'h4000, 32'd6, 2'b10);
    post(3, 32'h3000, 32'h4000, 32'd6, 1'b1, 1);
    wait_idle("drain_verify_bad_code");
    tb_success = 2'b01;

    // Zero-size descriptors respond without launching the DMA.
    @(posedge clk); #1;
    q_grant.push_back(3);
    q_resp.push_back({3'd3, 2'b00});
    post(3, 32'h5000, 32'h6000, 32'd0, 1'b0, 1);
    wait_idle("drain_size0_copy");
    @(posedge clk); #1;
    q_grant.push_back(0);
    q_resp.push_back({3'd0, 2'b01});
    post(0, 32'h5000, 32'h6000, 32'd0, 1'b1, 1);
    wait_idle("drain_size0_verify");

    // A stray done while idle must be ignored.
    @(posedge clk); #1;
    manual_req++;
    repeat (5) @(negedge clk);
    check("stray_done_busy", bus.busy, 1'b0);

    // Timeout: done withheld, status 11 only after the late done.
    @(posedge clk); #1;
    dma_lat = 0;
    expect_verify(1, 32'h7000, 32'h8000, 32'd16, 2'b11);
    post(1, 32'h7000, 32'h8000, 32'd16, 1'b1, 1);
    repeat (40) @(negedge clk);
    check("timeout_held", {bus.busy, 1'(q_resp.size() == 1), bus.cur_ch}, {1'b1, 1'b1, 2'd1});
    @(posedge clk); #1;
    manual_req++;
    wait_idle("drain_timeout");

    // Next descriptor is granted normally after the timeout.
    @(posedge clk); #1;
    dma_lat = 2;
    expect_copy(2, 32'h9000, 32'hA000, 32'd5);
    post(2, 32'h9000, 32'hA000, 32'd5, 1'b0, 1);
    wait_idle("drain_after_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
